// File: rtl/rsa_operand_buffer.sv
// rtl/rsa_operand_buffer.sv - RSA operand SRAM: write port, registered random read port, burst-read stream engine
// Burst fetches run one word ahead through a fetch register into a 2-entry output FIFO.
module rsa_operand_buffer #(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          bst_start,
  input  logic [AW-1:0] bst_base,
  input  logic [LW-1:0] bst_len,
  output logic          bst_busy,
  output logic          bst_valid,
  input  logic          bst_ready,
  output logic [DW-1:0] bst_data,
  output logic          bst_last,
  output logic          bst_done
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;
  state_e state_q, state_d;

  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] rd_data_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] left_q, left_d;
  logic          fetch_vld_q;
  logic          fetch_last_q;
  logic [DW-1:0] fetch_data_q;
  logic [DW-1:0] fifo_data_q [2];
  logic [1:0]    fifo_last_q;
  logic          fifo_rd_ptr_q, fifo_wr_ptr_q;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;
  logic          done_q, done_d;

  logic idle, start_run, start_empty, pop, last_pop, issue;

  assign idle        = (state_q == S_IDLE);
  assign start_run   = idle && bst_start && (bst_len != '0);
  assign start_empty = idle && bst_start && (bst_len == '0);
  assign pop         = bst_valid && bst_ready;
  assign last_pop    = pop && fifo_last_q[fifo_rd_ptr_q];

  // Occupancy after this edge counts the in-flight fetch; issuing only when it stays
  // below 2 guarantees the fetched word always has a FIFO slot on the next edge.
  assign fifo_cnt_d = fifo_cnt_q + {1'b0, fetch_vld_q} - {1'b0, pop};
  assign issue      = (state_q == S_RUN) && (left_q != '0) && (fifo_cnt_d < 2'd2);
  assign done_d     = last_pop || start_empty;

  // Array has no reset so operand contents survive rst_n; nonblocking write gives read-first.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_run) state_d = S_RUN;
      S_RUN:   if (last_pop)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    left_d = left_q;
    if (start_run) begin
      addr_d = bst_base;
      left_d = bst_len;
    end else if (issue) begin
      addr_d = addr_q + AW'(1);
      left_d = left_q - LW'(1);
    end
  end

  always_comb begin
    bst_busy  = (state_q == S_RUN);
    bst_valid = (fifo_cnt_q != 2'd0);
    bst_data  = fifo_data_q[fifo_rd_ptr_q];
    bst_last  = bst_valid && fifo_last_q[fifo_rd_ptr_q];
    bst_done  = done_q;
    rd_data   = rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      left_q         <= '0;
      rd_data_q      <= '0;
      fetch_vld_q    <= 1'b0;
      fetch_last_q   <= 1'b0;
      fetch_data_q   <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      fifo_rd_ptr_q  <= 1'b0;
      fifo_wr_ptr_q  <= 1'b0;
      fifo_cnt_q     <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      fifo_cnt_q  <= fifo_cnt_d;
      done_q      <= done_d;
      fetch_vld_q <= issue;
      if (rd_en && idle) begin
        rd_data_q <= mem[rd_addr];
      end
      if (issue) begin
        fetch_data_q <= mem[addr_q];
        fetch_last_q <= (left_q == LW'(1));
      end
      if (fetch_vld_q) begin
        fifo_data_q[fifo_wr_ptr_q] <= fetch_data_q;
        fifo_last_q[fifo_wr_ptr_q] <= fetch_last_q;
        fifo_wr_ptr_q              <= ~fifo_wr_ptr_q;
      end
      if (pop) begin
        fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      end
    end
  end
endmodule
